// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and result-function mode encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] MODE_INV  = 2'd0;
  localparam logic [1:0] MODE_PASS = 2'd1;
  localparam logic [1:0] MODE_INC  = 2'd2;
  localparam logic [1:0] MODE_REV  = 2'd3;

endpackage

// File: rtl/axi_lite_proc_unit.sv
// Combinational result function f(x), selected by the MODE register.
module axi_lite_proc_unit
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (mode)
      MODE_INV:  dout = ~din;
      MODE_PASS: dout = din;
      MODE_INC:  dout = din + DATA_WIDTH'(1);
      MODE_REV: begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          dout[i] = din[DATA_WIDTH-1-i];
        end
      end
      default:   dout = din;
    endcase
  end

endmodule

// File: rtl/axi_lite_regfile_proc.sv
// AXI-Lite register file: data registers, derived result registers and a MODE register.
module axi_lite_regfile_proc
  import axi_lite_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS) + 2
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] RES_BASE  = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] MODE_ADDR = ADDR_WIDTH'(2 * NUM_REGS);

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] upd,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < STRB_W; b++) begin
      m[8*b +: 8] = strb[b] ? upd[8*b +: 8] : cur[8*b +: 8];
    end
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] data_q   [NUM_REGS];
  logic [DATA_WIDTH-1:0] result_q [NUM_REGS];
  logic [1:0]            mode_q;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign AWREADY = !aw_held && !bvalid_q && !ARESET;
  assign WREADY  = !w_held && !bvalid_q && !ARESET;
  assign ARREADY = !rvalid_q && !ARESET;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  logic aw_hs, w_hs, ar_hs, commit;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // A beat arriving this cycle bypasses its holding register so the commit
  // edge is the same edge as the later of the two acceptances.
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, merged, proc_out;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_is_data, wr_is_mode;

  assign wr_addr    = aw_held ? aw_addr_q : AWADDR;
  assign wr_data    = w_held ? w_data_q : WDATA;
  assign wr_strb    = w_held ? w_strb_q : WSTRB;
  assign wr_idx     = wr_addr[IDX_W-1:0];
  assign wr_is_data = wr_addr < RES_BASE;
  assign wr_is_mode = wr_addr == MODE_ADDR;
  assign merged     = merge_bytes(data_q[wr_idx], wr_data, wr_strb);

  axi_lite_proc_unit #(.DATA_WIDTH(DATA_WIDTH)) u_proc (
    .mode (mode_q),
    .din  (merged),
    .dout (proc_out)
  );

  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  assign rd_idx = ARADDR[IDX_W-1:0];

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ARADDR < RES_BASE) begin
      rd_data = data_q[rd_idx];
    end else if (ARADDR < MODE_ADDR) begin
      rd_data = result_q[rd_idx];
    end else if (ARADDR == MODE_ADDR) begin
      rd_data = DATA_WIDTH'(mode_q);
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // Holding-register payloads are only meaningful while their flag is set.
  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_addr_q <= AWADDR;
    if (w_hs) begin
      w_data_q <= WDATA;
      w_strb_q <= WSTRB;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i]   <= '0;
        result_q[i] <= '0;
      end
      mode_q   <= MODE_INV;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end

      // BVALID blocks new AW/W beats, so a commit never overlaps a pending response.
      if (commit) begin
        bvalid_q <= 1'b1;
        if (wr_is_data) begin
          data_q[wr_idx]   <= merged;
          result_q[wr_idx] <= proc_out;
          bresp_q          <= RESP_OKAY;
        end else if (wr_is_mode) begin
          if (wr_strb[0]) mode_q <= wr_data[1:0];
          bresp_q <= RESP_OKAY;
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_proc.sv
// Randomised scoreboard bench for axi_lite_regfile_proc against an array-based reference model.
module tb_axi_lite_regfile_proc;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 4;
  localparam int TMO = 50;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_lite_regfile_proc #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  logic [31:0] m_data [NR];
  logic [31:0] m_res  [NR];
  logic [1:0]  m_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the spec's rules in plain arithmetic.
  function automatic logic [31:0] ref_f(input logic [31:0] x, input logic [1:0] md);
    logic [31:0] r;
    case (md)
      2'd0:    r = ~x;
      2'd1:    r = x;
      2'd2:    r = x + 32'd1;
      default: r = {<<{x}};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_data[i] = '0;
      m_res[i]  = '0;
    end
    m_mode = 2'd0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    if (a < NR) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_data[a[1:0]][8*b +: 8] = d[8*b +: 8];
      m_res[a[1:0]] = ref_f(m_data[a[1:0]], m_mode);
      resp = 2'b00;
    end else if (a == 2 * NR) begin
      if (s[0]) m_mode = d[1:0];
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  function automatic logic [33:0] model_read(input logic [3:0] a);
    if (a < NR)          return {2'b00, m_data[a[1:0]]};
    else if (a < 2 * NR) return {2'b00, m_res[a[1:0]]};
    else if (a == 2 * NR) return {2'b00, 30'd0, m_mode};
    else                 return {2'b10, 32'd0};
  endfunction

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge ACLK) begin
    if (!ARESET && BVALID && BREADY) begin
      if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else chk("bresp", 64'(BRESP), 64'(bq.pop_front()));
    end
    if (!ARESET && RVALID && RREADY) begin
      if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else chk("rresp_rdata", 64'({RRESP, RDATA}), 64'(rq.pop_front()));
    end
  end

  // Drivers all start and end 1 time unit after a rising edge.
  task automatic drive_aw(input logic [3:0] a, input int dly);
    bit done = 0;
    int n = 0;
    repeat (dly) begin @(posedge ACLK); #1; end
    AWADDR = a; AWVALID = 1'b1;
    while (!done) begin
      @(negedge ACLK); done = AWREADY;
      @(posedge ACLK); #1; n++;
      if (!done && n > TMO) begin chk("aw_timeout", 64'd0, 64'd1); done = 1; end
    end
    AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit done = 0;
    int n = 0;
    repeat (dly) begin @(posedge ACLK); #1; end
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    while (!done) begin
      @(negedge ACLK); done = WREADY;
      @(posedge ACLK); #1; n++;
      if (!done && n > TMO) begin chk("w_timeout", 64'd0, 64'd1); done = 1; end
    end
    WVALID = 1'b0;
  endtask

  task automatic drive_ar(input logic [3:0] a, input int dly);
    bit done = 0;
    int n = 0;
    repeat (dly) begin @(posedge ACLK); #1; end
    ARADDR = a; ARVALID = 1'b1;
    while (!done) begin
      @(negedge ACLK); done = ARREADY;
      @(posedge ACLK); #1; n++;
      if (!done && n > TMO) begin chk("ar_timeout", 64'd0, 64'd1); done = 1; end
    end
    ARVALID = 1'b0;
  endtask

  task automatic wait_b(input int dly);
    bit done = 0;
    int n = 0;
    repeat (dly) begin @(posedge ACLK); #1; end
    BREADY = 1'b1;
    while (!done) begin
      @(negedge ACLK); done = BVALID;
      @(posedge ACLK); #1; n++;
      if (!done && n > TMO) begin chk("b_timeout", 64'd0, 64'd1); done = 1; end
    end
    BREADY = 1'b0;
  endtask

  task automatic wait_r(input int dly);
    bit done = 0;
    int n = 0;
    repeat (dly) begin @(posedge ACLK); #1; end
    RREADY = 1'b1;
    while (!done) begin
      @(negedge ACLK); done = RVALID;
      @(posedge ACLK); #1; n++;
      if (!done && n > TMO) begin chk("r_timeout", 64'd0, 64'd1); done = 1; end
    end
    RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp;
    int da = $urandom_range(0, 3);
    int dw = $urandom_range(0, 3);
    model_write(a, d, s, resp);
    bq.push_back(resp);
    fork
      drive_aw(a, da);
      drive_w(d, s, dw);
    join
    wait_b($urandom_range(0, 3));
  endtask

  task automatic do_read(input logic [3:0] a);
    rq.push_back(model_read(a));
    drive_ar(a, $urandom_range(0, 2));
    wait_r($urandom_range(0, 3));
  endtask

  // Read and write to the same address committing on the same edge.
  task automatic do_conc(input logic [3:0] a, input logic [31:0] d);
    logic [1:0] resp;
    rq.push_back(model_read(a));
    model_write(a, d, 4'hF, resp);
    bq.push_back(resp);
    fork
      drive_aw(a, 0);
      drive_w(d, 4'hF, 0);
      drive_ar(a, 0);
    join
    wait_b(0);
    wait_r(0);
  endtask

  task automatic timing_check();
    logic [1:0] resp;
    model_write(4'd3, 32'hCAFE0003, 4'hF, resp);
    bq.push_back(resp);
    AWADDR = 4'd3; AWVALID = 1'b1;
    @(negedge ACLK); chk("awready_idle", 64'(AWREADY), 64'd1);
    @(posedge ACLK); #1; AWVALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin WDATA = 32'hCAFE0003; WSTRB = 4'hF; WVALID = 1'b1; end
      @(negedge ACLK);
      chk("awready_held", 64'(AWREADY), 64'd0);
      chk("bvalid_early", 64'(BVALID), 64'd0);
      if (c == 3) chk("wready_c3", 64'(WREADY), 64'd1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("bvalid_hold", 64'(BVALID), 64'd1);
      chk("awready_bv", 64'(AWREADY), 64'd0);
      chk("wready_bv", 64'(WREADY), 64'd0);
      @(posedge ACLK); #1;
    end
    wait_b(0);
    @(negedge ACLK); chk("awready_after_b", 64'(AWREADY), 64'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic reset_check();
    fork
      drive_aw(4'd0, 0);
      drive_w(32'h5555AAAA, 4'hF, 0);
      drive_ar(4'd5, 0);
    join
    @(negedge ACLK);
    chk("bvalid_pre_rst", 64'(BVALID), 64'd1);
    chk("rvalid_pre_rst", 64'(RVALID), 64'd1);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("awready_in_rst", 64'(AWREADY), 64'd0);
    chk("wready_in_rst", 64'(WREADY), 64'd0);
    chk("arready_in_rst", 64'(ARREADY), 64'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("bvalid_post_rst", 64'(BVALID), 64'd0);
    chk("rvalid_post_rst", 64'(RVALID), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    model_reset();
    for (int a = 0; a <= 2 * NR; a++) do_read(4'(a));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("idle_awready", 64'(AWREADY), 64'd1);
    chk("idle_arready", 64'(ARREADY), 64'd1);
    @(posedge ACLK); #1;
    for (int a = 0; a < 16; a++) do_read(4'(a));

    do_write(4'd1, 32'h12345678, 4'hF);
    do_read(4'd5);
    timing_check();
    do_write(4'd2, 32'hAABBCCDD, 4'hF);
    do_write(4'd2, 32'h11223344, 4'b0101);
    do_read(4'd2);
    do_read(4'd6);
    do_write(4'd8, 32'd2, 4'h1);
    do_write(4'd0, 32'hFFFFFFFF, 4'hF);
    do_read(4'd4);
    do_write(4'd8, 32'd3, 4'h1);
    do_write(4'd0, 32'h00000001, 4'hF);
    do_read(4'd4);
    do_read(4'd8);
    do_write(4'd8, 32'd1, 4'h0);
    do_read(4'd8);
    do_write(4'd6, 32'hDEADBEEF, 4'hF);
    do_read(4'd6);
    do_read(4'd12);
    do_write(4'd3, 32'h0F0F0F0F, 4'h0);
    do_read(4'd7);
    do_conc(4'd1, 32'h600DF00D);
    do_read(4'd1);

    for (int i = 0; i < 120; i++) begin
      int op = $urandom_range(0, 9);
      logic [3:0] a = 4'($urandom_range(0, 15));
      if (op < 5) do_write(a, $urandom, 4'($urandom_range(0, 15)));
      else if (op < 9) do_read(a);
      else do_conc(4'($urandom_range(0, NR - 1)), $urandom);
    end

    reset_check();
    repeat (4) begin @(posedge ACLK); #1; end
    chk("bq_drained", 64'(bq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
